// File: rtl/hdmi_timing_pkg.sv
// Shared 720p60 timing constants and colour constants for the HDMI output path.
package hdmi_timing_pkg;

    localparam int CNT_W = 12;

    localparam int H_ACTIVE_720 = 1280;
    localparam int H_FP_720     = 110;
    localparam int H_SYNC_720   = 40;
    localparam int H_BP_720     = 220;
    localparam int H_TOTAL_720  = H_SYNC_720 + H_BP_720 + H_ACTIVE_720 + H_FP_720;

    localparam int V_ACTIVE_720 = 720;
    localparam int V_FP_720     = 5;
    localparam int V_SYNC_720   = 5;
    localparam int V_BP_720     = 20;
    localparam int V_TOTAL_720  = V_SYNC_720 + V_BP_720 + V_ACTIVE_720 + V_FP_720;

    typedef logic [23:0] rgb_t;

    localparam rgb_t COLOR_BLACK = 24'h000000;
    localparam rgb_t COLOR_WHITE = 24'hFFFFFF;
    localparam rgb_t COLOR_RED   = 24'hFF0000;
    localparam rgb_t COLOR_GREEN = 24'h00FF00;
    localparam rgb_t COLOR_BLUE  = 24'h0000FF;

    // Strobe bundle carried through the delay line, held as output levels.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage

// File: rtl/sync_delay_line.sv
// Depth-N shift register for the sync/de strobes; every stage resets and clears
// to RST_VAL so a flush leaves the outputs idle.
module sync_delay_line #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] pipe;

            always_ff @(posedge clk_in or negedge reset_n) begin
                if (!reset_n) begin
                    pipe <= {DEPTH{RST_VAL}};
                end else if (clr) begin
                    pipe <= {DEPTH{RST_VAL}};
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign q = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: raw/active pixel coordinates plus sync/de strobes
// delayed to line up with the pattern generator's pipelined colour output.
module hdmi_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_720,
    parameter int   H_FP     = H_FP_720,
    parameter int   H_SYNC   = H_SYNC_720,
    parameter int   H_BP     = H_BP_720,
    parameter int   V_ACTIVE = V_ACTIVE_720,
    parameter int   V_FP     = V_FP_720,
    parameter int   V_SYNC   = V_SYNC_720,
    parameter int   V_BP     = V_BP_720,
    parameter logic SYNC_POL = 1'b1,
    parameter int   PIPE_DLY = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] loc_x,
    output logic [CNT_W-1:0] loc_y,
    output logic [CNT_W-1:0] act_x,
    output logic [CNT_W-1:0] act_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    localparam logic  IDLE_LVL  = ~SYNC_POL;
    localparam sync_t STRB_IDLE = '{hs: IDLE_LVL, vs: IDLE_LVL, de: 1'b0};

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             run;
    logic             hact, vact;
    sync_t            strb_i, strb_r, strb_d;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            run       <= 1'b0;
            frame_cnt <= '0;
        end else if (!en) begin
            hcnt <= '0;
            vcnt <= '0;
            run  <= 1'b0;
        end else begin
            run <= 1'b1;
            // The first enabled cycle parks on (0,0) so frame_start marks the restart.
            if (run) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (vcnt == V_LAST) begin
                        vcnt      <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else begin
                        vcnt <= vcnt + CNT_W'(1);
                    end
                end else begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        hact      = (hcnt >= HA_START) && (hcnt < HA_END);
        vact      = (vcnt >= VA_START) && (vcnt < VA_END);
        strb_i.hs = run && (hcnt < HS_END);
        strb_i.vs = run && (vcnt < VS_END);
        strb_i.de = run && hact && vact;
    end

    // Decode register converts to output polarity; it and the delay line
    // clear together when en drops so the strobes go idle on the next edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            strb_r <= STRB_IDLE;
        end else if (!en) begin
            strb_r <= STRB_IDLE;
        end else begin
            strb_r <= '{hs: strb_i.hs ^ IDLE_LVL, vs: strb_i.vs ^ IDLE_LVL, de: strb_i.de};
        end
    end

    sync_delay_line #(
        .W       (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (STRB_IDLE)
    ) u_dly (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clr     (~en),
        .d       (strb_r),
        .q       (strb_d)
    );

    assign loc_x       = hcnt;
    assign loc_y       = vcnt;
    assign act_x       = strb_i.de ? (hcnt - HA_START) : '0;
    assign act_y       = strb_i.de ? (vcnt - VA_START) : '0;
    assign frame_start = run && (hcnt == '0) && (vcnt == '0);
    assign hsync       = strb_d.hs;
    assign vsync       = strb_d.vs;
    assign de          = strb_d.de;

endmodule
